// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two memory requesters (CPU, debug/loader), the
// arbiter and the single-port RAM macro.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // Requester handshake: req is held high until the one-cycle ack pulse.
    // Inputs are sampled on the grant edge and may change afterwards.
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic [DATA_W-1:0] dbg_rdata;
    logic              dbg_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    logic [1:0]        out_owner;
    logic              out_busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
        output mem_addr, mem_wdata, mem_we,
        output out_owner, out_busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, dbg_rdata, dbg_ack,
        input  mem_addr, mem_wdata, mem_we,
        input  out_owner, out_busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port RAM between the CPU
// and debug ports; each transaction runs IDLE -> ACCESS -> CAPTURE.
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 in_reset,
    mem_port_arbiter_if.slave    bus,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    state_t            state;
    state_t            state_nx;
    logic              last_grant;   // 1 = debug was granted last
    logic [1:0]        owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              cpu_ack_q;
    logic              dbg_ack_q;

    logic              cpu_elig;
    logic              dbg_elig;
    logic              grant;
    logic              grant_dbg;

    // A port whose ack is showing this cycle is still finishing; its held req
    // must not start a second transaction.
    always_comb begin
        cpu_elig  = bus.cpu_req & ~cpu_ack_q;
        dbg_elig  = bus.dbg_req & ~dbg_ack_q;
        grant     = 1'b0;
        grant_dbg = 1'b0;
        state_nx  = state;
        case (state)
            IDLE: begin
                if (cpu_elig | dbg_elig) begin
                    grant     = 1'b1;
                    grant_dbg = (cpu_elig & dbg_elig) ? ~last_grant : dbg_elig;
                    state_nx  = ACCESS;
                end
            end
            ACCESS:  state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge in_reset) begin
        if (!in_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge in_reset) begin
        if (!in_reset) begin
            last_grant  <= 1'b1;
            owner       <= OWN_NONE;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            cpu_ack_q <= 1'b0;
            dbg_ack_q <= 1'b0;
            if (grant) begin
                last_grant <= grant_dbg;
                owner      <= grant_dbg ? OWN_DBG : OWN_CPU;
                lat_we     <= grant_dbg ? bus.dbg_we    : bus.cpu_we;
                lat_addr   <= grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
                lat_wdata  <= grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;
            end
            // RAM read data is valid during CAPTURE (one-cycle macro latency).
            if (state == CAPTURE) begin
                owner <= OWN_NONE;
                if (owner == OWN_CPU) begin
                    cpu_ack_q <= 1'b1;
                    if (!lat_we) cpu_rdata_q <= bus.mem_rdata;
                end else if (owner == OWN_DBG) begin
                    dbg_ack_q <= 1'b1;
                    if (!lat_we) dbg_rdata_q <= bus.mem_rdata;
                end
            end
        end
    end

    // mem_we is decoded from reset-cleared registers so it drops as soon as
    // in_reset falls, without waiting for a clock.
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;
    assign bus.mem_we    = (state == ACCESS) & lat_we;
    assign bus.out_owner = owner;
    assign bus.out_busy  = (state != IDLE);
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dbg_ack   = dbg_ack_q;
    assign fsm_state     = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: RAM model, directed scenarios, then random
// two-port traffic checked cycle by cycle against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic       clk;
  logic       in_reset;
  logic [1:0] fsm_state;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .in_reset  (in_reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    case (i)
      16:      return 32'hDEAD_BEEF;
      32:      return 32'h0200_2020;
      48:      return 32'h0300_3030;
      default: return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
    endcase
  endfunction

  // ---------------- RAM macro model (one-cycle read latency) ----------------
  logic [DW-1:0] ram [0:511];
  bit            ram_loaded = 1'b0;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // ---------------- reference model + scoreboard ----------------
  // One transaction at a time: granted from an idle cycle, occupies two
  // cycles (access, capture), then its ack shows in the following cycle.
  logic [DW-1:0] ref_mem [0:511];
  bit            ref_loaded = 1'b0;
  logic [DW-1:0] exp_q [$];
  bit            m_busy, m_age, m_who, m_last, m_we;
  bit            m_ack_c, m_ack_d, m_ack_rd;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, exp_crd, exp_drd;
  logic [1:0]    prev_owner;
  int            cyc = 0;
  int            ack_cnt_c = 0, ack_cnt_d = 0, we_cnt = 0;
  int            last_ack_c = 0, last_ack_d = 0;
  int            grant_q [$];

  always @(negedge clk) begin
    bit nx_c, nx_d, nx_rd, el_c, el_d, win;
    if (!ref_loaded) begin
      for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
      ref_loaded = 1'b1;
    end
    cyc++;
    if (!in_reset) begin
      m_busy = 0; m_age = 0; m_last = 1; m_who = 0; m_we = 0;
      m_ack_c = 0; m_ack_d = 0; m_ack_rd = 0;
      exp_crd = '0; exp_drd = '0; exp_q.delete(); prev_owner = 2'b00;
    end else begin
      // observation bookkeeping for directed checks
      if (bus.cpu_ack) begin ack_cnt_c++; last_ack_c = cyc; end
      if (bus.dbg_ack) begin ack_cnt_d++; last_ack_d = cyc; end
      if (bus.mem_we) we_cnt++;
      if (bus.out_owner != 2'b00 && prev_owner == 2'b00) grant_q.push_back(int'(bus.out_owner));
      prev_owner = bus.out_owner;

      // compare the present cycle
      check_eq("busy", 32'(bus.out_busy), 32'(m_busy));
      check_eq("owner", 32'(bus.out_owner), m_busy ? (m_who ? 32'd2 : 32'd1) : 32'd0);
      check_eq("cpu_ack", 32'(bus.cpu_ack), 32'(m_ack_c));
      check_eq("dbg_ack", 32'(bus.dbg_ack), 32'(m_ack_d));
      check_eq("mem_we", 32'(bus.mem_we), 32'(m_busy && !m_age && m_we));
      check_eq("cpu_rdata", bus.cpu_rdata, exp_crd);
      check_eq("dbg_rdata", bus.dbg_rdata, exp_drd);
      if (m_busy) check_eq("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      if (m_busy && !m_age && m_we) check_eq("mem_wdata", bus.mem_wdata, m_wdata);
      if ((m_ack_c || m_ack_d) && m_ack_rd && exp_q.size() > 0) begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        check_eq("read_result", m_ack_d ? bus.dbg_rdata : bus.cpu_rdata, e);
      end

      // advance to the next cycle
      nx_c = 0; nx_d = 0; nx_rd = 0;
      if (m_busy) begin
        if (m_age) begin
          if (m_we) ref_mem[m_addr] = m_wdata;
          if (m_who) nx_d = 1; else nx_c = 1;
          if (!m_we) begin
            nx_rd = 1;
            exp_q.push_back(ref_mem[m_addr]);
            if (m_who) exp_drd = ref_mem[m_addr]; else exp_crd = ref_mem[m_addr];
          end
          m_busy = 0;
        end else begin
          m_age = 1;
        end
      end else begin
        el_c = bus.cpu_req && !m_ack_c;
        el_d = bus.dbg_req && !m_ack_d;
        if (el_c || el_d) begin
          win     = (el_c && el_d) ? !m_last : el_d;
          m_busy  = 1; m_age = 0; m_who = win; m_last = win;
          m_we    = win ? bus.dbg_we    : bus.cpu_we;
          m_addr  = win ? bus.dbg_addr  : bus.cpu_addr;
          m_wdata = win ? bus.dbg_wdata : bus.cpu_wdata;
        end
      end
      m_ack_c = nx_c; m_ack_d = nx_d; m_ack_rd = nx_rd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_port(input bit port, input logic req, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (port) begin
      bus.dbg_req = req; bus.dbg_we = we; bus.dbg_addr = a; bus.dbg_wdata = d;
    end else begin
      bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d;
    end
  endtask

  // Raise req, hold until ack (bounded), then drop. With scramble set, addr
  // and wdata are changed each cycle once the grant is visible.
  task automatic drive_txn(input bit port, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit scramble);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_port(port, 1'b1, we, a, d);
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (port ? bus.dbg_ack : bus.cpu_ack) begin
        got = 1'b1;
      end else if (scramble && bus.out_owner == (port ? 2'b10 : 2'b01)) begin
        @(posedge clk); #1;
        set_port(port, 1'b1, we, AW'($urandom_range(0, 511)), $urandom);
      end
    end
    check_eq(port ? "dbg_ack_timeout" : "cpu_ack_timeout", 32'(got), 32'd1);
    @(posedge clk); #1;
    set_port(port, 1'b0, we, a, d);
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return 9'h1FF;
    return AW'($urandom_range(0, 15));
  endfunction

  task automatic rand_thread(input bit port, input int n);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drive_txn(port, 1'($urandom_range(0, 1)), pick_addr(), $urandom, 1'b1);
    end
  endtask

  task automatic do_reset();
    in_reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 in_reset = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base_c, base_d, base_we, base_g;
    in_reset = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, '0, '0);
    set_port(1'b1, 1'b0, 1'b0, '0, '0);
    #2;
    check_eq("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
    check_eq("rst_dbg_rdata", bus.dbg_rdata, 32'd0);
    check_eq("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check_eq("rst_dbg_ack", 32'(bus.dbg_ack), 32'd0);
    check_eq("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check_eq("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check_eq("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_owner", 32'(bus.out_owner), 32'd0);
    check_eq("rst_busy", 32'(bus.out_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 in_reset = 1'b1;

    // CPU read of a preloaded word
    base_d = ack_cnt_d;
    drive_txn(1'b0, 1'b0, 9'h010, '0, 1'b0);
    check_eq("cpu_read_data", bus.cpu_rdata, 32'hDEAD_BEEF);
    check_eq("cpu_read_no_dbg_ack", 32'(ack_cnt_d - base_d), 32'd0);

    // debug write at the top address, then CPU reads it back
    base_we = we_cnt;
    drive_txn(1'b1, 1'b1, 9'h1FF, 32'h1234_5678, 1'b0);
    check_eq("dbg_write_we_cycles", 32'(we_cnt - base_we), 32'd1);
    drive_txn(1'b0, 1'b0, 9'h1FF, '0, 1'b0);
    check_eq("cpu_readback", bus.cpu_rdata, 32'h1234_5678);
    check_eq("dbg_rdata_kept", bus.dbg_rdata, 32'd0);

    // tie straight after reset: CPU first, debug three cycles later
    do_reset();
    base_g = grant_q.size();
    fork
      drive_txn(1'b0, 1'b0, 9'h020, '0, 1'b0);
      drive_txn(1'b1, 1'b0, 9'h030, '0, 1'b0);
    join
    check_eq("tie_first", 32'(grant_q[base_g]), 32'd1);
    check_eq("tie_second", 32'(grant_q[base_g + 1]), 32'd2);
    check_eq("tie_ack_gap", 32'(last_ack_d - last_ack_c), 32'd3);

    // both ports hold req for 12 cycles
    @(posedge clk); #1;
    base_c = ack_cnt_c; base_d = ack_cnt_d; base_g = grant_q.size();
    set_port(1'b0, 1'b1, 1'b0, AW'($urandom_range(0, 511)), '0);
    set_port(1'b1, 1'b1, 1'b0, AW'($urandom_range(0, 511)), '0);
    repeat (12) @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.dbg_req = 1'b0;
    repeat (4) @(posedge clk);
    check_eq("held_cpu_acks", 32'(ack_cnt_c - base_c), 32'd2);
    check_eq("held_dbg_acks", 32'(ack_cnt_d - base_d), 32'd2);
    for (int i = 0; i < 4; i++)
      check_eq("held_grant_order", 32'(grant_q[base_g + i]), (i % 2 == 0) ? 32'd1 : 32'd2);

    // reset asserted in the ACCESS cycle of a CPU write
    fork
      drive_txn(1'b0, 1'b1, 9'h055, 32'hCAFE_F00D, 1'b0);
      begin
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
          @(negedge clk);
          if (bus.out_owner == 2'b01 && bus.mem_we) ok = 1'b1;
        end
        check_eq("rst_reach_access", 32'(ok), 32'd1);
        #2 in_reset = 1'b0;
        #1;
        check_eq("async_mem_we", 32'(bus.mem_we), 32'd0);
        check_eq("async_owner", 32'(bus.out_owner), 32'd0);
        check_eq("async_busy", 32'(bus.out_busy), 32'd0);
        check_eq("async_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check_eq("async_mem_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("async_mem_wdata", bus.mem_wdata, 32'd0);
        check_eq("async_cpu_rdata", bus.cpu_rdata, 32'd0);
        repeat (2) @(posedge clk);
        #1 in_reset = 1'b1;
      end
    join
    check_eq("rst_write_after_release", ram[9'h055], 32'hCAFE_F00D);

    // CPU changes its address one cycle after the grant
    fork
      drive_txn(1'b0, 1'b0, 9'h020, '0, 1'b0);
      begin
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
          @(negedge clk);
          if (bus.out_owner == 2'b01) ok = 1'b1;
        end
        check_eq("chg_reach_grant", 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.cpu_addr = 9'h030;
        @(negedge clk);
        check_eq("chg_mem_addr", 32'(bus.mem_addr), 32'h020);
      end
    join
    check_eq("chg_rdata", bus.cpu_rdata, 32'h0200_2020);

    // random traffic from both ports
    fork
      rand_thread(1'b0, 30);
      rand_thread(1'b1, 30);
    join
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
